// File: rtl/hazard_control_unit_if.sv
// Hazard control bus: pipeline-side hazard inputs and the PC/pipeline-register
// enable/flush controls returned by hazard_control_unit.
// master = pipeline datapath side, slave = hazard_control_unit.
interface hazard_control_unit_if;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic [4:0] ex_rd;
  logic       ex_MemRead;
  logic       ex_branch_taken;
  logic       mem_MemRead;
  logic       mem_MemWrite;
  logic       pc_write;
  logic       if_id_write;
  logic       id_ex_write;
  logic       ex_mem_write;
  logic       mem_wb_write;
  logic       if_id_flush;
  logic       id_ex_bubble;
  logic       mem_stall;

  modport master (
    output id_rs1, id_rs2, ex_rd, ex_MemRead, ex_branch_taken, mem_MemRead, mem_MemWrite,
    input  pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
           if_id_flush, id_ex_bubble, mem_stall
  );

  modport slave (
    input  id_rs1, id_rs2, ex_rd, ex_MemRead, ex_branch_taken, mem_MemRead, mem_MemWrite,
    output pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
           if_id_flush, id_ex_bubble, mem_stall
  );
endinterface

// File: rtl/hazard_control_unit.sv
// hazard_control_unit: stall/flush sequencer for the 5-stage RISC-V pipeline.
// Handles load-use bubbles, taken-branch flushes and multi-cycle data-memory
// freezes. Control outputs are Mealy (same-cycle) from state plus inputs.
// Optional feature macro: HAZARD_PERF_CNT_EN adds 32-bit stall/flush
// performance counters (stall_cnt, flush_cnt ports).
module hazard_control_unit #(
  parameter int MEM_LAT = 3,
  parameter int CNT_W   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  hazard_control_unit_if.slave hzBus
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]          stall_cnt,
  output logic [31:0]          flush_cnt
`endif
);

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  // A latency of 1 completes within the MEM cycle and never freezes.
  localparam logic             MULTI_CYCLE = (MEM_LAT > 1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  // Entry cycle is already frozen, so the wait counter covers the remaining MEM_LAT-2.
  localparam logic [CNT_W-1:0] CNT_LOAD    = MULTI_CYCLE ? CNT_W'(MEM_LAT - 2) : CNT_ZERO;

  state_t           state_r;
  state_t           nextState_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] nextCnt_s;
  logic             memReq_s;
  logic             memStall_s;
  logic             loadUse_s;

  assign memReq_s  = hzBus.mem_MemRead | hzBus.mem_MemWrite;
  assign loadUse_s = hzBus.ex_MemRead && (hzBus.ex_rd != 5'd0) &&
                     ((hzBus.ex_rd == hzBus.id_rs1) || (hzBus.ex_rd == hzBus.id_rs2));

  // State and latency counter registers; reset aborts any pending wait.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= RUN;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= nextState_s;
      cnt_r   <= nextCnt_s;
    end
  end

  // Next-state / counter logic and the raw freeze condition.
  always_comb begin
    nextState_s = state_r;
    nextCnt_s   = cnt_r;
    memStall_s  = 1'b0;
    case (state_r)
      RUN: begin
        if (memReq_s && MULTI_CYCLE) begin
          nextState_s = MEM_WAIT;
          nextCnt_s   = CNT_LOAD;
          memStall_s  = 1'b1;
        end else begin
          nextState_s = RUN;
          nextCnt_s   = cnt_r;
          memStall_s  = 1'b0;
        end
      end
      MEM_WAIT: begin
        if (cnt_r == CNT_ZERO) begin
          // Release cycle: access completes, pipeline advances.
          nextState_s = RUN;
          nextCnt_s   = CNT_ZERO;
          memStall_s  = 1'b0;
        end else begin
          nextState_s = MEM_WAIT;
          nextCnt_s   = cnt_r - CNT_ONE;
          memStall_s  = 1'b1;
        end
      end
      default: begin
        nextState_s = RUN;
        nextCnt_s   = CNT_ZERO;
        memStall_s  = 1'b0;
      end
    endcase
  end

  // Prioritised control outputs: reset > freeze > flush > load-use > normal.
  always_comb begin
    hzBus.pc_write     = 1'b1;
    hzBus.if_id_write  = 1'b1;
    hzBus.id_ex_write  = 1'b1;
    hzBus.ex_mem_write = 1'b1;
    hzBus.mem_wb_write = 1'b1;
    hzBus.if_id_flush  = 1'b0;
    hzBus.id_ex_bubble = 1'b0;
    hzBus.mem_stall    = 1'b0;
    if (rst) begin
      hzBus.mem_stall = 1'b0;
    end else if (memStall_s) begin
      // Upstream inputs are held during the freeze, so other hazards are
      // simply re-evaluated once it releases.
      hzBus.pc_write     = 1'b0;
      hzBus.if_id_write  = 1'b0;
      hzBus.id_ex_write  = 1'b0;
      hzBus.ex_mem_write = 1'b0;
      hzBus.mem_wb_write = 1'b0;
      hzBus.mem_stall    = 1'b1;
    end else if (hzBus.ex_branch_taken) begin
      // Squashing ID also removes any load-use dependency it carried.
      hzBus.if_id_flush  = 1'b1;
      hzBus.id_ex_bubble = 1'b1;
    end else if (loadUse_s) begin
      hzBus.pc_write     = 1'b0;
      hzBus.if_id_write  = 1'b0;
      hzBus.id_ex_bubble = 1'b1;
    end else begin
      hzBus.id_ex_bubble = 1'b0;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic stallEvt_s;
  logic flushEvt_s;

  // A bubble without a flush is a load-use stall.
  assign stallEvt_s = hzBus.mem_stall | (hzBus.id_ex_bubble & ~hzBus.if_id_flush);
  assign flushEvt_s = hzBus.if_id_flush;

  // Performance counters, free-running modulo 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      if (stallEvt_s) begin
        stall_cnt <= stall_cnt + 32'd1;
      end else begin
        stall_cnt <= stall_cnt;
      end
      if (flushEvt_s) begin
        flush_cnt <= flush_cnt + 32'd1;
      end else begin
        flush_cnt <= flush_cnt;
      end
    end
  end
`else
  // Without performance counters there is no additional state.
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Testbench for hazard_control_unit. Three lanes share one stimulus:
// lane 0 MEM_LAT=3, lane 1 MEM_LAT=1, lane 2 MEM_LAT=4.
// Expected control vectors are queued when stimulus is applied and checked
// at the following falling edge.
module tb_hazard_control_unit;

  // Control vector: {pc, if_id, id_ex, ex_mem, mem_wb, flush, bubble, stall}
  localparam logic [7:0] N  = 8'b11111_000; // normal
  localparam logic [7:0] F  = 8'b00000_001; // memory freeze
  localparam logic [7:0] FL = 8'b11111_110; // branch flush
  localparam logic [7:0] LU = 8'b00111_010; // load-use bubble

  typedef struct {
    string      name;
    int         lane;
    logic [7:0] exp;
  } sbEntry_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] idRs1 = 5'd0;
  logic [4:0] idRs2 = 5'd0;
  logic [4:0] exRd = 5'd0;
  logic       exMemRead = 1'b0;
  logic       exBranch = 1'b0;
  logic       memRead = 1'b0;
  logic       memWrite = 1'b0;
  logic [7:0] ctl [3];
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stallCnt [3];
  logic [31:0] flushCnt [3];
`endif

  sbEntry_t sb[$];
  int testsRun = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : gLane
    hazard_control_unit_if hif();
    assign hif.id_rs1          = idRs1;
    assign hif.id_rs2          = idRs2;
    assign hif.ex_rd           = exRd;
    assign hif.ex_MemRead      = exMemRead;
    assign hif.ex_branch_taken = exBranch;
    assign hif.mem_MemRead     = memRead;
    assign hif.mem_MemWrite    = memWrite;
    hazard_control_unit #(
      .MEM_LAT((g == 0) ? 3 : ((g == 1) ? 1 : 4)),
      .CNT_W(4)
    ) dut (
      .clk(clk),
      .rst(rst),
      .hzBus(hif.slave)
`ifdef HAZARD_PERF_CNT_EN
      ,
      .stall_cnt(stallCnt[g]),
      .flush_cnt(flushCnt[g])
`endif
    );
    assign ctl[g] = {hif.pc_write, hif.if_id_write, hif.id_ex_write, hif.ex_mem_write,
                     hif.mem_wb_write, hif.if_id_flush, hif.id_ex_bubble, hif.mem_stall};
  end

  // Scoreboard consumer: compare every queued expectation mid-cycle.
  always @(negedge clk) begin
    sbEntry_t e;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      testsRun++;
      if (ctl[e.lane] !== e.exp) begin
        testsFailed++;
        $display("FAIL %s lane%0d: got %b expected %b", e.name, e.lane, ctl[e.lane], e.exp);
      end
    end
  end

  task automatic idle();
    idRs1 = 5'd0; idRs2 = 5'd0; exRd = 5'd0;
    exMemRead = 1'b0; exBranch = 1'b0; memRead = 1'b0; memWrite = 1'b0;
  endtask

  // Queue expectations for all lanes for the current inputs, then advance one cycle.
  task automatic step(input string name, input logic [7:0] e0, input logic [7:0] e1,
                      input logic [7:0] e2);
    sb.push_back('{name, 0, e0});
    sb.push_back('{name, 1, e1});
    sb.push_back('{name, 2, e2});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    exBranch = 1'b1; memRead = 1'b1; exMemRead = 1'b1; exRd = 5'd3; idRs1 = 5'd3;
    #1;
    for (int i = 0; i < 3; i++) begin
      testsRun++;
      if (ctl[i] !== N) begin
        testsFailed++;
        $display("FAIL reset_outputs lane%0d: got %b expected %b", i, ctl[i], N);
      end
    end
    step("reset_hold", N, N, N);
`ifdef HAZARD_PERF_CNT_EN
    for (int i = 0; i < 3; i++) begin
      testsRun++;
      if (stallCnt[i] !== 32'd0 || flushCnt[i] !== 32'd0) begin
        testsFailed++;
        $display("FAIL reset_counters lane%0d: got %0d/%0d expected 0/0", i, stallCnt[i], flushCnt[i]);
      end
    end
`endif
    rst = 1'b0;
    idle();
    step("post_reset", N, N, N);
  endtask

  task automatic test_load_use();
    exMemRead = 1'b1; exRd = 5'd5; idRs2 = 5'd5; idRs1 = 5'd9;
    step("lu_rs2", LU, LU, LU);
    idle();
    step("lu_release", N, N, N);
    exMemRead = 1'b1; exRd = 5'd7; idRs1 = 5'd7; idRs2 = 5'd1;
    step("lu_rs1", LU, LU, LU);
    exMemRead = 1'b1; exRd = 5'd7; idRs1 = 5'd6; idRs2 = 5'd8;
    step("lu_nomatch", N, N, N);
    idle();
  endtask

  task automatic test_rd_zero();
    exMemRead = 1'b1; exRd = 5'd0; idRs1 = 5'd0; idRs2 = 5'd0;
    step("rd_zero", N, N, N);
    idle();
  endtask

  task automatic test_mem_freeze();
    memRead = 1'b1;
    step("frz_T0", F, N, F);
    step("frz_T1", F, N, F);
    step("frz_T2", N, N, F);
    memRead = 1'b0;
    step("frz_T3", N, N, N);
    memWrite = 1'b1;
    step("frz_wr0", F, N, F);
    memWrite = 1'b0;
    step("frz_wr1", F, N, F);
    step("frz_wr2", N, N, F);
    step("frz_wr3", N, N, N);
  endtask

  task automatic test_back_to_back();
    memRead = 1'b1;
    step("b2b_0", F, N, F);
    step("b2b_1", F, N, F);
    step("b2b_2", N, N, F);
    step("b2b_3", F, N, N);
    step("b2b_4", F, N, F);
    step("b2b_5", N, N, F);
    memRead = 1'b0;
    step("b2b_6", N, N, F);
    step("b2b_7", N, N, N);
  endtask

  task automatic test_branch_load_use();
    exBranch = 1'b1; exMemRead = 1'b1; exRd = 5'd5; idRs1 = 5'd5;
    step("br_lu", FL, FL, FL);
    idle();
    step("br_lu_next", N, N, N);
    exBranch = 1'b1;
    step("br_only", FL, FL, FL);
    idle();
  endtask

  task automatic test_branch_freeze();
    exBranch = 1'b1; memRead = 1'b1;
    step("brf_0", F, FL, F);
    step("brf_1", F, FL, F);
    step("brf_2", FL, FL, F);
    step("brf_3", F, FL, FL);
    idle();
    step("brf_4", F, N, N);
    step("brf_5", N, N, N);
  endtask

  task automatic test_reset_mid_freeze();
    memRead = 1'b1;
    step("rmf_enter", F, N, F);
    rst = 1'b1; memRead = 1'b0;
    step("rmf_reset", N, N, N);
    rst = 1'b0;
    step("rmf_after", N, N, N);
`ifdef HAZARD_PERF_CNT_EN
    testsRun++;
    if (stallCnt[0] !== 32'd0) begin
      testsFailed++;
      $display("FAIL rmf_cnt_clear: got %0d expected 0", stallCnt[0]);
    end
`endif
    memRead = 1'b1;
    step("rmf_frz0", F, N, F);
    step("rmf_frz1", F, N, F);
    step("rmf_frz2", N, N, F);
    memRead = 1'b0;
    step("rmf_frz3", N, N, N);
`ifdef HAZARD_PERF_CNT_EN
    testsRun++;
    if (stallCnt[0] !== 32'd2 || stallCnt[2] !== 32'd3 || stallCnt[1] !== 32'd0) begin
      testsFailed++;
      $display("FAIL rmf_stall_cnt: got %0d/%0d/%0d expected 2/0/3", stallCnt[0], stallCnt[1], stallCnt[2]);
    end
    testsRun++;
    if (flushCnt[0] !== 32'd0) begin
      testsFailed++;
      $display("FAIL rmf_flush_cnt: got %0d expected 0", flushCnt[0]);
    end
`endif
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_load_use();
    test_rd_zero();
    test_mem_freeze();
    test_back_to_back();
    test_branch_load_use();
    test_branch_freeze();
    test_reset_mid_freeze();
    @(posedge clk);
    #1;
    testsRun++;
    if (sb.size() != 0) begin
      testsFailed++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
